// File: rtl/midi_pkg.sv
// Shared constants and state encodings for the MIDI note decoder.
package midi_pkg;

  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] NOTE_OFF = 4'h8;

  localparam logic [7:0] SYS_COMMON_LO = 8'hF0;
  localparam logic [7:0] SYS_COMMON_HI = 8'hF7;
  localparam logic [7:0] REALTIME_LO   = 8'hF8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    P_NONE = 2'd0,
    P_KEY  = 2'd1,
    P_VEL  = 2'd2
  } parse_state_t;

  typedef enum logic [1:0] {
    RS_ON     = 2'd0,
    RS_OFF    = 2'd1,
    RS_IGNORE = 2'd2
  } rs_kind_t;

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver with input synchronizer, mid-bit sampling and
// start-bit glitch rejection.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLOCK_RATE_HZ = 50000000,
  parameter int unsigned BAUD_RATE     = 31250
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_ferr
);

  localparam int unsigned BIT_CYC  = CLOCK_RATE_HZ / BAUD_RATE;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = $clog2(BIT_CYC) + 1;

  rx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_armed, w_armed_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic [1:0]       r_sync;
  logic             w_rx;

  assign w_rx    = r_sync[1];
  assign o_byte  = r_shift;
  assign o_valid = r_valid;
  assign o_ferr  = r_ferr;

  // Synchronizer resets low so the line must be observed idle before a start bit counts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_armed <= 1'b0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_armed <= w_armed_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_armed_nxt = r_armed;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (w_rx) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_armed_nxt = 1'b0;
          w_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (r_cnt == CNT_W'(HALF_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (r_cnt == CNT_W'(BIT_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (r_cnt == CNT_W'(BIT_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          w_valid_nxt = w_rx;
          w_ferr_nxt  = ~w_rx;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI note decoder: UART receive, running-status parse,
// last-note-priority note/velocity/gate outputs.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int unsigned CLOCK_RATE_HZ = 50000000,
  parameter int unsigned BAUD_RATE     = 31250,
  parameter int unsigned MIDI_CHANNEL  = 0,
  parameter bit          OMNI          = 1'b0
) (
  input  logic       inCLK,
  input  logic       inRSTn,
  input  logic       inMidiRx,
  output logic [6:0] outMidiFrequencyIndex,
  output logic [6:0] outVelocity,
  output logic       outGate,
  output logic       outNoteStrobe,
  output logic       outFramingError
);

  logic [7:0]   w_byte;
  logic         w_valid;
  logic         w_chan_ok;

  parse_state_t r_pstate, w_pstate_nxt;
  rs_kind_t     r_kind, w_kind_nxt;
  logic [6:0]   r_key, w_key_nxt;
  logic         w_exec_nxt;

  logic         r_exec;
  rs_kind_t     r_exec_kind;
  logic [6:0]   r_exec_key, r_exec_vel;

  logic [6:0]   r_index, w_index_nxt;
  logic [6:0]   r_vel, w_vel_nxt;
  logic         r_gate, w_gate_nxt;
  logic         r_strobe, w_changed;

  midi_uart_rx #(
    .CLOCK_RATE_HZ(CLOCK_RATE_HZ),
    .BAUD_RATE    (BAUD_RATE)
  ) u_rx (
    .i_clk  (inCLK),
    .i_rst_n(inRSTn),
    .i_rx   (inMidiRx),
    .o_byte (w_byte),
    .o_valid(w_valid),
    .o_ferr (outFramingError)
  );

  assign w_chan_ok             = OMNI || (w_byte[3:0] == 4'(MIDI_CHANNEL));
  assign outMidiFrequencyIndex = r_index;
  assign outVelocity           = r_vel;
  assign outGate               = r_gate;
  assign outNoteStrobe         = r_strobe;

  always_ff @(posedge inCLK or negedge inRSTn) begin
    if (!inRSTn) begin
      r_pstate    <= P_NONE;
      r_kind      <= RS_IGNORE;
      r_key       <= '0;
      r_exec      <= 1'b0;
      r_exec_kind <= RS_IGNORE;
      r_exec_key  <= '0;
      r_exec_vel  <= '0;
      r_index     <= '0;
      r_vel       <= '0;
      r_gate      <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_pstate <= w_pstate_nxt;
      r_kind   <= w_kind_nxt;
      r_key    <= w_key_nxt;
      r_exec   <= w_exec_nxt;
      if (w_exec_nxt) begin
        r_exec_kind <= r_kind;
        r_exec_key  <= r_key;
        r_exec_vel  <= w_byte[6:0];
      end
      r_index  <= w_index_nxt;
      r_vel    <= w_vel_nxt;
      r_gate   <= w_gate_nxt;
      r_strobe <= w_changed;
    end
  end

  // Byte parser: real-time bytes are transparent, any status byte abandons a partial message.
  always_comb begin
    w_pstate_nxt = r_pstate;
    w_kind_nxt   = r_kind;
    w_key_nxt    = r_key;
    w_exec_nxt   = 1'b0;
    if (w_valid) begin
      if (w_byte >= REALTIME_LO) begin
        w_pstate_nxt = r_pstate;
      end else if ((w_byte >= SYS_COMMON_LO) && (w_byte <= SYS_COMMON_HI)) begin
        w_pstate_nxt = P_NONE;
        w_kind_nxt   = RS_IGNORE;
      end else if (w_byte[7]) begin
        w_pstate_nxt = P_KEY;
        if ((w_byte[7:4] == NOTE_ON) && w_chan_ok)       w_kind_nxt = RS_ON;
        else if ((w_byte[7:4] == NOTE_OFF) && w_chan_ok) w_kind_nxt = RS_OFF;
        else                                             w_kind_nxt = RS_IGNORE;
      end else begin
        case (r_pstate)
          P_KEY: begin
            w_key_nxt    = w_byte[6:0];
            w_pstate_nxt = P_VEL;
          end
          P_VEL: begin
            w_exec_nxt   = 1'b1;
            w_pstate_nxt = P_KEY;
          end
          default: w_pstate_nxt = P_NONE;
        endcase
      end
    end
  end

  // Message execution; note-off only releases the note currently sounding.
  always_comb begin
    w_index_nxt = r_index;
    w_vel_nxt   = r_vel;
    w_gate_nxt  = r_gate;
    if (r_exec) begin
      case (r_exec_kind)
        RS_ON: begin
          if (r_exec_vel != 7'd0) begin
            w_index_nxt = r_exec_key;
            w_vel_nxt   = r_exec_vel;
            w_gate_nxt  = 1'b1;
          end else if (r_exec_key == r_index) begin
            w_gate_nxt = 1'b0;
          end
        end
        RS_OFF: begin
          if (r_exec_key == r_index) w_gate_nxt = 1'b0;
        end
        default: w_gate_nxt = r_gate;
      endcase
    end
    w_changed = (w_index_nxt != r_index) || (w_vel_nxt != r_vel) || (w_gate_nxt != r_gate);
  end

endmodule

// File: doc/midi_note_decoder.md
MIDI_NOTE_DECODER -- requirements
Module: midi_note_decoder

Interface
REQ-001 SHALL have parameter CLOCK_RATE_HZ, default 50000000, meaning the inCLK frequency.
REQ-002 SHALL have parameter BAUD_RATE, default 31250, meaning the MIDI serial bit rate.
REQ-003 SHALL have parameter MIDI_CHANNEL, default 0, meaning the accepted channel (0-15).
REQ-004 SHALL have parameter OMNI, default 0, meaning accept all channels when 1.
REQ-005 SHALL have port inCLK, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 SHALL have port inRSTn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port inMidiRx, input, 1 bit: asynchronous MIDI serial line, idle high.
REQ-008 SHALL have port outMidiFrequencyIndex, output, 7 bits: current note number, which drives the sample generator index.
REQ-009 SHALL have port outVelocity, output, 7 bits: velocity of the current note.
REQ-010 SHALL have port outGate, output, 1 bit: high while the current note is held.
REQ-011 SHALL have port outNoteStrobe, output, 1 bit: one-cycle pulse when index, velocity or gate is updated.
REQ-012 SHALL have port outFramingError, output, 1 bit: one-cycle pulse when a byte has a bad stop bit.

Function
REQ-013 SHALL pass inMidiRx through a 2-flop synchronizer before any use.
REQ-014 SHALL use a bit period BIT_CYC = CLOCK_RATE_HZ/BAUD_RATE (integer division); the bit counter width SHALL be clog2(BIT_CYC)+1.
REQ-015 Receiver FSM states SHALL be RX_IDLE, RX_START, RX_DATA and RX_STOP.
- RX_IDLE to RX_START: on a synchronized falling edge.
- RX_START: re-check at BIT_CYC/2; if low, go to RX_DATA; if high, treat as a glitch and return to RX_IDLE with no error.
- RX_DATA: sample 8 bits LSB first, each BIT_CYC apart, at bit centres.
- RX_STOP: sample at the centre. If 1, pulse the internal byte-valid for one cycle. If 0, pulse outFramingError and discard the byte.
- Either stop outcome: go to RX_IDLE, then wait for the line to return high before detecting a new start bit.
REQ-016 Parser states SHALL be P_NONE (no running status), P_KEY and P_VEL. Running-status kind SHALL be ON, OFF or IGNORE.
REQ-017 A status byte 0x9n SHALL set running status ON and go to P_KEY, if n==MIDI_CHANNEL or OMNI=1; 0x8n SHALL likewise set OFF.
REQ-018 Any other 0x80-0xEF byte, and any 0x8n/0x9n byte on another channel, SHALL set running status IGNORE and go to P_KEY.
REQ-019 Bytes 0xF0-0xF7 SHALL clear running status and go to P_NONE.
REQ-020 Bytes 0xF8-0xFF (real-time) SHALL be ignored with no state change, including mid-message.
REQ-021 A data byte (bit7=0) SHALL be handled by state:
- P_NONE: dropped.
- P_KEY: latch the key, go to P_VEL.
- P_VEL: execute the message, return to P_KEY (running status kept).
REQ-022 A status byte arriving in P_VEL SHALL abandon the partial message.
REQ-023 Execute ON with vel>0 SHALL set index=key, velocity=vel, gate=1 (monophonic, last-note priority).
REQ-024 Execute OFF, or ON with vel=0, SHALL clear gate only if key==outMidiFrequencyIndex; otherwise no output change.
REQ-025 Execute IGNORE SHALL change no outputs.
REQ-026 Outputs and outNoteStrobe SHALL update exactly 2 cycles after the stop-bit centre sample; the strobe SHALL pulse only when an output changed.

Reset
REQ-027 Assertion of inRSTn SHALL immediately force, regardless of inCLK:
- outputs: index=0, velocity=0, gate=0, strobe=0, error=0;
- receiver: RX_IDLE; parser: P_NONE.
REQ-028 A reset mid-byte or mid-message SHALL discard that byte or message entirely.
REQ-029 After deassertion, the first accepted start bit SHALL require the line to be seen high first.

Structure
REQ-030 Package midi_pkg SHALL hold the status nibbles (NOTE_ON=4'h9, NOTE_OFF=4'h8), the real-time and system-common bounds, and the receiver/parser state encodings.
REQ-031 The UART receiver (REQ-013 to REQ-015) SHALL be sub-module midi_uart_rx, with outputs byte[7:0], byte-valid and framing-error.

Verification (CLOCK_RATE_HZ=3125000, so BIT_CYC=100)
REQ-032 Send 0x90,0x45,0x64 -> 2 cycles after the last stop centre: index=69, velocity=100, gate=1, one strobe.
REQ-033 Running status: after REQ-032, send 0x48,0x20 then 0x45,0x00 -> first: index=72, gate=1; second: gate stays 1 (key mismatch), no strobe.
REQ-034 Send 0x90,0x3C,0xF8,0x50 -> the real-time byte is transparent; index=60, velocity=80, gate=1.
REQ-035 Send 0x91,0x3C,0x50 with MIDI_CHANNEL=0, OMNI=0 -> no output change. Repeat with OMNI=1 -> gate=1, index=60.
REQ-036 Send a byte with stop bit=0 -> one outFramingError pulse; parser state unchanged. Also send a 30-cycle low glitch -> no byte, no error.
REQ-037 Assert inRSTn low during the data bits of a velocity byte -> all outputs 0 at once. A following 0x45,0x64 without a status byte SHALL be dropped.
